// File: rtl/jtdsp16_sio_ctrl_if.sv
// Sample-request, serial-output load and status signals of jtdsp16_sio_ctrl.
// slave is the scheduler; master is the producer/serial-unit side.
interface jtdsp16_sio_ctrl_if;
  logic [15:0] l_data;
  logic        l_valid;
  logic        l_ready;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_ready;
  logic        obe;
  logic        sio_imm_load;
  logic [2:0]  r_field;
  logic [15:0] long_imm;
  logic        busy;
  logic        err;
  logic        underrun;

  modport master (
    output l_data, l_valid, r_data, r_valid, obe,
    input  l_ready, r_ready, sio_imm_load, r_field, long_imm, busy, err, underrun
  );

  modport slave (
    input  l_data, l_valid, r_data, r_valid, obe,
    output l_ready, r_ready, sio_imm_load, r_field, long_imm, busy, err, underrun
  );
endinterface

// File: rtl/jtdsp16_sio_ctrl.sv
// Feeds SIOC once, then SRTA+SDX loads per L/R sample; SRTA 1 ph1 after selection, SDX 1 ph1 later.
// *_ready drops while a holding register is full. Option macro: JTDSP16_SIO_ZERO_FILL_EN (strict L/R alternation with zero fill).
module jtdsp16_sio_ctrl #(
  parameter logic [15:0] SIOC_CFG = 16'h02E8,
  parameter logic [7:0]  ADDR_L   = 8'h00,
  parameter logic [7:0]  ADDR_R   = 8'h80,
  parameter int          TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ph1,
  jtdsp16_sio_ctrl_if.slave   sio
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {INIT, IDLE, LD_SRTA, LD_SDX, WAIT_BUSY, WAIT_EMPTY} state_t;

  state_t      state_q;
  logic        l_full_q, r_full_q;
  logic [15:0] l_hold_q, r_hold_q;
  logic        ptr_q;
  logic        sel_q;
  logic [7:0]  tmo_q;
  logic        load_q, busy_q, err_q;
  logic [2:0]  field_q;
  logic [15:0] imm_q;
  logic        pick, pick_vld;
  logic        l_cap, r_cap;
  logic [15:0] sel_dat;

  assign sio.l_ready      = !l_full_q;
  assign sio.r_ready      = !r_full_q;
  assign sio.sio_imm_load = load_q;
  assign sio.r_field      = field_q;
  assign sio.long_imm     = imm_q;
  assign sio.busy         = busy_q;
  assign sio.err          = err_q;

  assign l_cap   = sio.l_valid && !l_full_q && ph1;
  assign r_cap   = sio.r_valid && !r_full_q && ph1;
  assign sel_dat = sel_q ? r_hold_q : l_hold_q;

`ifdef JTDSP16_SIO_ZERO_FILL_EN
  logic [3:0] idle_q;
  logic       zf_q, und_q;
  logic       ptr_full;

  assign ptr_full     = ptr_q ? r_full_q : l_full_q;
  assign sio.underrun = und_q;

  // The expected channel is always served; an empty one is replaced by zero after 16 idle ph1.
  always_comb begin
    pick     = ptr_q;
    pick_vld = ptr_full || (idle_q == 4'd15);
  end
`else
  assign sio.underrun = 1'b0;

  // Work-conserving: the pointer only arbitrates when both channels are waiting.
  always_comb begin
    pick     = (l_full_q && r_full_q) ? ptr_q : !l_full_q;
    pick_vld = l_full_q || r_full_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      l_full_q <= 1'b0;
      r_full_q <= 1'b0;
      l_hold_q <= 16'h0000;
      r_hold_q <= 16'h0000;
      ptr_q    <= 1'b0;
      sel_q    <= 1'b0;
      tmo_q    <= 8'd0;
      load_q   <= 1'b0;
      field_q  <= 3'd0;
      imm_q    <= 16'h0000;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
`ifdef JTDSP16_SIO_ZERO_FILL_EN
      idle_q   <= 4'd0;
      zf_q     <= 1'b0;
      und_q    <= 1'b0;
`endif
    end else begin
      if (l_cap) begin
        l_full_q <= 1'b1;
        l_hold_q <= sio.l_data;
      end
      if (r_cap) begin
        r_full_q <= 1'b1;
        r_hold_q <= sio.r_data;
      end
      if (ph1) begin
        load_q <= 1'b0;
`ifdef JTDSP16_SIO_ZERO_FILL_EN
        und_q  <= 1'b0;
`endif
        case (state_q)
          INIT: begin
            load_q  <= 1'b1;
            field_q <= 3'd0;
            imm_q   <= SIOC_CFG;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          IDLE: begin
            if (pick_vld) begin
              sel_q   <= pick;
              busy_q  <= 1'b1;
              state_q <= LD_SRTA;
`ifdef JTDSP16_SIO_ZERO_FILL_EN
              ptr_q   <= !ptr_q;
              zf_q    <= !ptr_full;
              idle_q  <= 4'd0;
            end else begin
              idle_q  <= idle_q + 4'd1;
`else
              if (l_full_q && r_full_q) ptr_q <= !ptr_q;
`endif
            end
          end
          LD_SRTA: begin
            load_q  <= 1'b1;
            field_q <= 3'd1;
            imm_q   <= {8'h00, (sel_q ? ADDR_R : ADDR_L)};
            state_q <= LD_SDX;
          end
          LD_SDX: begin
            load_q  <= 1'b1;
            field_q <= 3'd2;
            tmo_q   <= 8'd0;
            state_q <= WAIT_BUSY;
`ifdef JTDSP16_SIO_ZERO_FILL_EN
            imm_q   <= zf_q ? 16'h0000 : sel_dat;
            und_q   <= zf_q;
            if (!zf_q) begin
              if (sel_q) r_full_q <= 1'b0;
              else       l_full_q <= 1'b0;
            end
`else
            imm_q   <= sel_dat;
            if (sel_q) r_full_q <= 1'b0;
            else       l_full_q <= 1'b0;
`endif
          end
          WAIT_BUSY: begin
            tmo_q <= tmo_q + 8'd1;
            if (!sio.obe) begin
              state_q <= WAIT_EMPTY;
            end else if (tmo_q == TMO_LAST) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          WAIT_EMPTY: begin
            tmo_q <= tmo_q + 8'd1;
            if (sio.obe || (tmo_q == TMO_LAST)) begin
              // A word still shifting at the deadline is written off as lost.
              if (!sio.obe) err_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
